// File: rtl/mem_pkg.sv
// mem_pkg: state encoding for the memory port arbiter and the shared ResultSrc load code
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DATA_BUSY  = 2'd1,
    FETCH_BUSY = 2'd2,
    RESP       = 2'd3
  } mem_state_t;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: wait-state counter that flags expiry at TIMEOUT-1
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int CW = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CW-1:0] cnt;
  // count wait cycles of the current transaction, restart whenever the port is not busy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
  assign expired = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM load/store, data first
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int TIMEOUT = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic [31:0]   if_rdata,
  output logic          if_done,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  input  logic [3:0]    dm_be,
  output logic [31:0]   dm_rdata,
  output logic          dm_done,
  output logic          stall_if,
  output logic          stall_dm,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err
);
  mem_state_t state, state_nx;
  logic dm_any, busy, fin, expired, grant, kill_q, kill_eff, fetch_ok;

  assign dm_any   = dm_read | dm_write;
  assign busy     = state == DATA_BUSY || state == FETCH_BUSY;
  assign fin      = busy & (mem_ready | expired);
  assign grant    = state == IDLE && (dm_any || if_req);
  assign kill_eff = kill_q | if_kill;
  assign fetch_ok = fin && state == FETCH_BUSY && !kill_eff;
  assign stall_dm = dm_any & ~dm_done;
  assign stall_if = if_req & ~if_done & ~if_kill;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT), .CW(CW)) u_tmo (
    .clk(clk), .rst_n(rst_n), .clr(!busy), .en(busy && !mem_ready), .expired(expired)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // arbitration in IDLE (data wins), one RESP cycle after every completion or abort
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = dm_any ? DATA_BUSY : (if_req ? FETCH_BUSY : IDLE);
    else if (state == RESP) state_nx = IDLE;
    else if (fin) state_nx = RESP;
  end

  // kill flag: a redirected fetch still completes on the bus but is never delivered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) kill_q <= 1'b0;
    else if (state == RESP) kill_q <= 1'b0;
    else if (if_kill && (state == FETCH_BUSY || (grant && !dm_any))) kill_q <= 1'b1;

  // registered memory request, capture of returned data and completion pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      dm_rdata  <= '0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      if_done   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      dm_done <= fin && state == DATA_BUSY;
      if_done <= fetch_ok;
      bus_err <= fin && !mem_ready;
      if (grant) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_write;
        mem_addr  <= dm_any ? dm_addr : if_addr;
        mem_wdata <= dm_any ? dm_wdata : '0;
        mem_be    <= dm_write ? dm_be : 4'hF;
      end else if (fin) mem_req <= 1'b0;
      if (fin && state == DATA_BUSY) dm_rdata <= mem_ready ? mem_rdata : '0;
      if (fetch_ok) if_rdata <= mem_ready ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table, hand-written and random transactions against a transaction-level model
module tb_mem_port_arbiter;
  localparam int TO = 16;

  typedef struct {
    logic dr, dw, ir;
    logic [31:0] daddr, iaddr, wdata, rdata;
    logic [3:0] be;
    int waits, kill;
    logic exp_data, exp_we;
    logic [3:0] exp_be;
    int exp_cyc;
    logic exp_err;
  } vec_t;

  logic clk = 0, rst_n = 0;
  logic if_req = 0, if_kill = 0, dm_read = 0, dm_write = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [3:0] dm_be = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_done, dm_done, stall_if, stall_dm, mem_req, mem_we, bus_err;
  logic [3:0] mem_be;
  int errors = 0, checks = 0;
  logic [31:0] last_if = 0;

  mem_port_arbiter #(.AW(32), .TIMEOUT(TO), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_done(if_done), .dm_read(dm_read), .dm_write(dm_write),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .stall_if(stall_if), .stall_dm(stall_dm), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.dr = 1'($urandom_range(0, 1));
    v.dw = 1'($urandom_range(0, 1));
    v.ir = 1'($urandom_range(0, 1));
    if (!(v.dr || v.dw || v.ir)) v.ir = 1'b1;
    v.daddr = $urandom; v.iaddr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
    v.be = 4'($urandom_range(0, 15));
    v.waits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO - 1, TO + 1)) : int'($urandom_range(0, 3));
    v.exp_data = v.dr | v.dw;
    v.exp_we = v.dw;
    v.exp_be = v.dw ? v.be : 4'hF;
    v.exp_err = v.waits >= TO;
    v.exp_cyc = v.exp_err ? TO : v.waits + 1;
    v.kill = (!v.exp_data && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, v.exp_cyc)) : -1;
    return v;
  endfunction

  task automatic run(input vec_t v);
    logic [31:0] exp_addr, exp_rd;
    logic killed, exp_ifd;
    int n, cyc;
    bit fin;
    exp_addr = v.exp_data ? v.daddr : v.iaddr;
    exp_rd = v.exp_err ? 32'h0 : v.rdata;
    killed = v.kill >= 0 && !v.exp_data;
    exp_ifd = !v.exp_data && !killed;
    dm_read = v.dr; dm_write = v.dw; if_req = v.ir;
    dm_addr = v.daddr; if_addr = v.iaddr; dm_wdata = v.wdata; dm_be = v.be;
    if_kill = v.kill == 0; mem_ready = 0;
    #1;
    chk("stall_dm_req", 32'(stall_dm), 32'(v.dr | v.dw));
    chk("stall_if_req", 32'(stall_if), 32'(v.ir & ~if_kill));
    @(posedge clk);
    n = 0; cyc = 1; fin = 0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      if (mem_req) begin
        n++;
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", 32'(mem_we), 32'(v.exp_we));
        chk("mem_be", 32'(mem_be), 32'(v.exp_be));
        if (v.exp_data) chk("mem_wdata", mem_wdata, v.wdata);
        mem_ready = n == v.waits + 1;
        mem_rdata = mem_ready ? v.rdata : $urandom;
        if_kill = cyc == v.kill;
        #1;
        chk("stall_dm_busy", 32'(stall_dm), 32'(v.dr | v.dw));
        chk("stall_if_busy", 32'(stall_if), 32'(v.ir & ~if_kill));
        cyc++;
      end else fin = 1;
    end
    if (!fin) begin
      errors++;
      $display("FAIL txn_bound: mem_req still high after %0d cycles", cyc);
    end
    mem_ready = 0; if_kill = 0;
    #1;
    chk("req_cycles", 32'(n), 32'(v.exp_cyc));
    chk("dm_done", 32'(dm_done), 32'(v.exp_data));
    chk("if_done", 32'(if_done), 32'(exp_ifd));
    chk("bus_err", 32'(bus_err), 32'(v.exp_err));
    if (v.exp_data) chk("dm_rdata", dm_rdata, exp_rd);
    else chk("if_rdata", if_rdata, killed ? last_if : exp_rd);
    if (exp_ifd) last_if = exp_rd;
    chk("stall_dm_done", 32'(stall_dm), 32'((v.dr | v.dw) & ~v.exp_data));
    chk("stall_if_done", 32'(stall_if), 32'(v.ir & ~exp_ifd));
    @(posedge clk);
    @(negedge clk);
    chk("no_relaunch", 32'(mem_req), 32'h0);
    chk("done_cleared", 32'({dm_done, if_done, bus_err}), 32'h0);
    if (v.exp_data) begin dm_read = 0; dm_write = 0; end
    else if_req = 0;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0,0,1, 32'h0,   32'h40, 32'h0,        32'h00500093, 4'h0,    0, -1, 0,0,4'hF,    1, 0};
    tbl[1] = '{1,0,1, 32'h100, 32'h44, 32'h0,        32'h12345678, 4'h0,    1, -1, 1,0,4'hF,    2, 0};
    tbl[2] = '{0,0,1, 32'h0,   32'h44, 32'h0,        32'h00a00113, 4'h0,    0, -1, 0,0,4'hF,    1, 0};
    tbl[3] = '{0,1,0, 32'h200, 32'h0,  32'hDEADBEEF, 32'h0,        4'b0011, 3, -1, 1,1,4'b0011, 4, 0};
    tbl[4] = '{1,0,0, 32'h300, 32'h0,  32'h0,        32'hCAFE0000, 4'h0,   40, -1, 1,0,4'hF,   TO, 1};
    tbl[5] = '{0,0,1, 32'h0,   32'h48, 32'h0,        32'h11111111, 4'h0,    2,  1, 0,0,4'hF,    3, 0};
    tbl[6] = '{0,0,1, 32'h0,   32'h4c, 32'h0,        32'h22222222, 4'h0,    0,  0, 0,0,4'hF,    1, 0};
    tbl[7] = '{1,0,0, 32'h304, 32'h0,  32'h0,        32'hABCD0123, 4'h0, TO-1, -1, 1,0,4'hF,   TO, 0};
    tbl[8] = '{1,1,0, 32'h308, 32'h0,  32'h55AA55AA, 32'h0,        4'b1100, 0, -1, 1,1,4'b1100, 1, 0};
    tbl[9] = '{0,0,1, 32'h0,   32'h50, 32'h0,        32'h33333333, 4'h0,   TO, -1, 0,0,4'hF,   TO, 1};
    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'({mem_req, mem_we, mem_be, if_done, dm_done, bus_err}), 32'h0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
    rst_n = 1;
    @(negedge clk);
    foreach (tbl[i]) run(tbl[i]);
    dm_write = 1; dm_addr = 32'h400; dm_wdata = 32'h1; dm_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_req", 32'({mem_req, mem_we}), 32'h3);
    #2 rst_n = 0;
    #1;
    chk("async_rst_req", 32'({mem_req, mem_we, dm_done, if_done}), 32'h0);
    dm_write = 0;
    last_if = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run('{1,0,0, 32'h404, 32'h0, 32'h0, 32'h0BADF00D, 4'h0, 1, -1, 1,0,4'hF, 2, 0});
    for (int i = 0; i < 30; i++) run(rand_vec());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
